// File: rtl/rtl_bigreg_writer_pkg.sv
// Shared mem-map layout constants and the bigreg writer state type.
// The PS-side assembler is expected to reuse these IDs.
package rtl_bigreg_writer_pkg;

    function automatic int bigreg_samples(input int data_width, input int word_width);
        return data_width / word_width;
    endfunction

    localparam int WD_DATA_WIDTH        = 16;
    localparam int WD_BUS_WIDTH         = 32;
    localparam int MEM_MAP_SIZE         = 256;
    localparam int BUFF_TIMESTAMP_WIDTH = 32;
    localparam int BUFF_TIME_BASE_ID    = 27;
    localparam int BUFF_SAMPLES         = bigreg_samples(BUFF_TIMESTAMP_WIDTH, WD_DATA_WIDTH);
    localparam int BUFF_TIME_VALID_ID   = BUFF_TIME_BASE_ID + BUFF_SAMPLES;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WRITE_VALID
    } writer_state_t;

endpackage

// File: rtl/rtl_bigreg_writer.sv
// Publishes a wide value into consecutive mem-map entries, LS slice first,
// then marks it valid so the PS never observes a partially written value.
module rtl_bigreg_writer
    import rtl_bigreg_writer_pkg::*;
#(
    parameter int DATA_WIDTH       = BUFF_TIMESTAMP_WIDTH,
    parameter int WORD_WIDTH       = WD_DATA_WIDTH,
    parameter int BUS_WIDTH        = WD_BUS_WIDTH,
    parameter int MEM_SIZE         = MEM_MAP_SIZE,
    parameter int BASE_ID          = BUFF_TIME_BASE_ID,
    parameter int WAIT_FOR_CONSUME = 1,
    parameter int DROP_CNT_WIDTH   = 8,
    localparam int SAMPLES         = bigreg_samples(DATA_WIDTH, WORD_WIDTH),
    localparam int VALID_ID        = BASE_ID + SAMPLES,
    localparam int ID_WIDTH        = $clog2(MEM_SIZE)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     data_in,
    input  logic                      data_valid_in,
    output logic                      data_ready_out,
    input  logic                      valid_pending_in,
    output logic                      wr_en_out,
    output logic [ID_WIDTH-1:0]       wr_id_out,
    output logic [BUS_WIDTH-1:0]      wr_data_out,
    input  logic                      wr_ack_in,
    output logic                      done_out,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt_out
);

    localparam int K_W = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
    localparam logic [K_W-1:0]      K_LAST     = K_W'(SAMPLES - 1);
    localparam logic [ID_WIDTH-1:0] BASE_ID_W  = ID_WIDTH'(BASE_ID);
    localparam logic [ID_WIDTH-1:0] VALID_ID_W = ID_WIDTH'(VALID_ID);

    if (DATA_WIDTH % WORD_WIDTH != 0) begin : g_chk_div
        $fatal(1, "DATA_WIDTH must be a multiple of WORD_WIDTH");
    end
    if (WORD_WIDTH > BUS_WIDTH) begin : g_chk_word
        $fatal(1, "WORD_WIDTH must not exceed BUS_WIDTH");
    end
    if (VALID_ID >= MEM_SIZE) begin : g_chk_id
        $fatal(1, "VALID_ID must lie inside the mem map");
    end

    function automatic logic [BUS_WIDTH-1:0] zext(input logic [WORD_WIDTH-1:0] w);
        logic [BUS_WIDTH-1:0] r;
        r = '0;
        r[WORD_WIDTH-1:0] = w;
        return r;
    endfunction

    writer_state_t         state;
    logic [K_W-1:0]        k;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_next;

    // The latched value shifts down one slice per ack, so the current slice is always at the bottom.
    assign data_next = data_q >> WORD_WIDTH;

    assign data_ready_out = !rst && (state == ST_IDLE)
                            && !((WAIT_FOR_CONSUME != 0) && valid_pending_in);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            k            <= '0;
            data_q       <= '0;
            wr_en_out    <= 1'b0;
            wr_id_out    <= '0;
            wr_data_out  <= '0;
            done_out     <= 1'b0;
            drop_cnt_out <= '0;
        end else begin
            done_out <= 1'b0;
            if (data_valid_in && !data_ready_out && (drop_cnt_out != '1)) begin
                drop_cnt_out <= drop_cnt_out + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (data_valid_in && data_ready_out) begin
                        data_q      <= data_in;
                        k           <= '0;
                        state       <= ST_WRITE;
                        wr_en_out   <= 1'b1;
                        wr_id_out   <= BASE_ID_W;
                        wr_data_out <= zext(data_in[WORD_WIDTH-1:0]);
                    end
                end
                ST_WRITE: begin
                    if (wr_ack_in) begin
                        if (k == K_LAST) begin
                            state       <= ST_WRITE_VALID;
                            wr_id_out   <= VALID_ID_W;
                            wr_data_out <= BUS_WIDTH'(1);
                        end else begin
                            k           <= k + 1'b1;
                            data_q      <= data_next;
                            wr_id_out   <= wr_id_out + 1'b1;
                            wr_data_out <= zext(data_next[WORD_WIDTH-1:0]);
                        end
                    end
                end
                ST_WRITE_VALID: begin
                    if (wr_ack_in) begin
                        state       <= ST_IDLE;
                        wr_en_out   <= 1'b0;
                        wr_id_out   <= '0;
                        wr_data_out <= '0;
                        done_out    <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    wr_en_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rtl_bigreg_writer.sv
// Scoreboard bench for rtl_bigreg_writer: default, small drop counter and
// 256-bit wide instances share clock and reset.
module tb_rtl_bigreg_writer;

    typedef struct {
        int          id;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    exp_t q0[$];
    exp_t q2[$];

    // default instance
    logic [31:0] d0 = '0;
    logic        v0 = 1'b0, p0 = 1'b0, ack0 = 1'b1;
    logic        rdy0, en0, done0;
    logic [7:0]  id0;
    logic [31:0] wd0;
    logic [7:0]  drop0;

    // 4-bit drop counter instance
    logic [31:0] d1 = '0;
    logic        v1 = 1'b0, p1 = 1'b0, ack1 = 1'b1;
    logic        rdy1, en1, done1;
    logic [7:0]  id1;
    logic [31:0] wd1;
    logic [3:0]  drop1;

    // 256-bit instance at BASE_ID 33
    logic [255:0] d2 = '0;
    logic         v2 = 1'b0, p2 = 1'b0, ack2 = 1'b1;
    logic         rdy2, en2, done2;
    logic [7:0]   id2;
    logic [31:0]  wd2;
    logic [7:0]   drop2;

    rtl_bigreg_writer dut0 (
        .clk(clk), .rst(rst), .data_in(d0), .data_valid_in(v0), .data_ready_out(rdy0),
        .valid_pending_in(p0), .wr_en_out(en0), .wr_id_out(id0), .wr_data_out(wd0),
        .wr_ack_in(ack0), .done_out(done0), .drop_cnt_out(drop0)
    );

    rtl_bigreg_writer #(.DROP_CNT_WIDTH(4)) dut1 (
        .clk(clk), .rst(rst), .data_in(d1), .data_valid_in(v1), .data_ready_out(rdy1),
        .valid_pending_in(p1), .wr_en_out(en1), .wr_id_out(id1), .wr_data_out(wd1),
        .wr_ack_in(ack1), .done_out(done1), .drop_cnt_out(drop1)
    );

    rtl_bigreg_writer #(.DATA_WIDTH(256), .BASE_ID(33)) dut2 (
        .clk(clk), .rst(rst), .data_in(d2), .data_valid_in(v2), .data_ready_out(rdy2),
        .valid_pending_in(p2), .wr_en_out(en2), .wr_id_out(id2), .wr_data_out(wd2),
        .wr_ack_in(ack2), .done_out(done2), .drop_cnt_out(drop2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push0(input int id, input logic [31:0] data);
        exp_t e;
        e.id = id;
        e.data = data;
        q0.push_back(e);
    endtask

    // Monitors: every cycle a request is up it must match the queue head; an ack retires it.
    always @(negedge clk) begin
        if (!rst && en0) begin
            if (q0.size() == 0) begin
                chk("dut0_unexpected_write_id", 32'(id0), 32'hFFFF_FFFF);
            end else begin
                chk("dut0_wr_id", 32'(id0), 32'(q0[0].id));
                chk("dut0_wr_data", wd0, q0[0].data);
                if (ack0) void'(q0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && en2) begin
            if (q2.size() == 0) begin
                chk("dut2_unexpected_write_id", 32'(id2), 32'hFFFF_FFFF);
            end else begin
                chk("dut2_wr_id", 32'(id2), 32'(q2[0].id));
                chk("dut2_wr_data", wd2, q2[0].data);
                if (ack2) void'(q2.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && en1) chk("dut1_no_write", 32'(en1), 32'd0);
    end

    // Presents a value and returns the cycle number in which it was accepted.
    task automatic send(input int which, input logic [255:0] v, output int acc);
        bit got;
        got = 1'b0;
        acc = -1;
        @(posedge clk); #1;
        if (which == 0) begin d0 = v[31:0]; v0 = 1'b1; end
        else begin d2 = v; v2 = 1'b1; end
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if ((which == 0) ? rdy0 : rdy2) begin
                got = 1'b1;
                acc = cyc;
            end
        end
        if (!got) chk("send_timeout_ready", 32'd0, 32'd1);
        @(posedge clk); #1;
        v0 = 1'b0;
        v2 = 1'b0;
    endtask

    task automatic wait_done(input int which, input int exp_cyc, input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 80 && !got; i++) begin
            @(negedge clk);
            if ((which == 0) ? done0 : done2) begin
                got = 1'b1;
                chk({name, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
                chk({name, "_ready_at_done"}, 32'((which == 0) ? rdy0 : rdy2), 32'd1);
                @(negedge clk);
                chk({name, "_done_pulse"}, 32'((which == 0) ? done0 : done2), 32'd0);
            end
        end
        if (!got) chk({name, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int acc;
        logic [255:0] wide;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(rdy0), 32'd0);
        chk("rst_wr_en", 32'(en0), 32'd0);
        chk("rst_wr_id", 32'(id0), 32'd0);
        chk("rst_wr_data", wd0, 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_drop", 32'(drop0), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic publish with ack tied high
        push0(27, 32'h0000_BEEF);
        push0(28, 32'h0000_DEAD);
        push0(29, 32'h1);
        send(0, 256'hDEAD_BEEF, acc);
        wait_done(0, acc + 4, "basic");

        // Ack stall on slice 1
        push0(27, 32'h0000_BEEF);
        push0(28, 32'h0000_DEAD);
        push0(29, 32'h1);
        send(0, 256'hDEAD_BEEF, acc);
        @(posedge clk); #1;
        ack0 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        ack0 = 1'b1;
        wait_done(0, acc + 9, "stall");

        // Pending blocks acceptance and counts drops
        push0(27, 32'h0000_5A5A);
        push0(28, 32'h0000_A5A5);
        push0(29, 32'h1);
        @(posedge clk); #1;
        p0 = 1'b1;
        d0 = 32'hA5A5_5A5A;
        v0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0 || i == 9) chk("pending_ready", 32'(rdy0), 32'd0);
            @(posedge clk);
        end
        #1;
        p0 = 1'b0;
        @(negedge clk);
        chk("pending_drop_cnt", 32'(drop0), 32'd10);
        chk("pending_release_ready", 32'(rdy0), 32'd1);
        acc = cyc;
        @(posedge clk); #1;
        v0 = 1'b0;
        wait_done(0, acc + 4, "pending");
        chk("drop_cnt_hold", 32'(drop0), 32'd10);

        // Saturating 4-bit drop counter
        @(posedge clk); #1;
        p1 = 1'b1;
        v1 = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        v1 = 1'b0;
        @(negedge clk);
        chk("drop_saturate", 32'(drop1), 32'd15);
        p1 = 1'b0;

        // Reset in the middle of a sequence, slice 28 outstanding
        push0(27, 32'h0000_F00D);
        push0(28, 32'h0000_CAFE);
        send(0, 256'hCAFE_F00D, acc);
        @(posedge clk); #1;
        ack0 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_wr_en_async", 32'(en0), 32'd0);
        chk("midrst_drop_cleared", 32'(drop0), 32'd0);
        q0.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        ack0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_no_valid_write", 32'(en0), 32'd0);
        end
        push0(27, 32'h0000_5678);
        push0(28, 32'h0000_1234);
        push0(29, 32'h1);
        send(0, 256'h1234_5678, acc);
        wait_done(0, acc + 4, "after_rst");

        // 256-bit value: slice i carries 0x1000+i
        wide = '0;
        for (int i = 0; i < 16; i++) begin
            exp_t e;
            wide[i*16 +: 16] = 16'h1000 + 16'(i);
            e.id = 33 + i;
            e.data = 32'h1000 + 32'(i);
            q2.push_back(e);
        end
        begin
            exp_t e;
            e.id = 49;
            e.data = 32'h1;
            q2.push_back(e);
        end
        send(2, wide, acc);
        wait_done(2, acc + 18, "wide");

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q2_drained", 32'(q2.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rtl_bigreg_writer.md
Name: rtl_bigreg_writer

Overview:
- RTL-side producer for RTL_BIGREG mem-map entries, such as the buffer timestamp at BUFF_TIME_BASE_ID..BUFF_TIME_VALID_ID.
- Accepts one wide value from fabric logic and splits it into WD_DATA_WIDTH slices.
- Writes the slices into consecutive mem-map IDs, least-significant slice first, then writes 1 to the associated valid ID.
- Sits between the producing RTL (buffer/timestamp logic) and the mem-map RTL write port; it is the write-side counterpart to the PS reading these registers.

Parameters:
- DATA_WIDTH, 32, width of the wide register (BUFF_TIMESTAMP_WIDTH).
- WORD_WIDTH, 16, payload bits per mem-map entry (WD_DATA_WIDTH).
- BUS_WIDTH, 32, width of the mem-map data word (WD_BUS_WIDTH); each slice is zero-extended to this width.
- MEM_SIZE, 256, number of mem-map entries.
- BASE_ID, 27, first mem-map ID written (BUFF_TIME_BASE_ID).
- WAIT_FOR_CONSUME, 1, if 1, no new value is accepted while the PS has not yet cleared the valid entry.
- DROP_CNT_WIDTH, 8, width of the saturating drop counter.
- Derived (localparam): SAMPLES = DATA_WIDTH/WORD_WIDTH, VALID_ID = BASE_ID+SAMPLES, ID_WIDTH = $clog2(MEM_SIZE).

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-high reset.
- data_in, in, DATA_WIDTH, wide value to publish.
- data_valid_in, in, 1, data_in is valid.
- data_ready_out, out, 1, block can accept data_in this cycle.
- valid_pending_in, in, 1, mem-map entry VALID_ID is currently nonzero (the PS has not yet consumed it).
- wr_en_out, out, 1, mem-map write request.
- wr_id_out, out, ID_WIDTH, mem-map ID of the write.
- wr_data_out, out, BUS_WIDTH, mem-map write data.
- wr_ack_in, in, 1, mem-map accepted the write this cycle.
- done_out, out, 1, one-cycle pulse after the valid write is acked.
- drop_cnt_out, out, DROP_CNT_WIDTH, saturating count of cycles where data_valid_in=1 and data_ready_out=0.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state IDLE, slice index k=0, latched data 0;
  - wr_en_out=0, wr_id_out=0, wr_data_out=0, done_out=0, drop_cnt_out=0;
  - data_ready_out=0 while rst is high.
- States are IDLE, WRITE, WRITE_VALID.
- IDLE:
  - data_ready_out = !(WAIT_FOR_CONSUME && valid_pending_in).
  - On data_valid_in && data_ready_out: register data_in, set k=0, next state WRITE.
- WRITE:
  - wr_en_out=1, wr_id_out=BASE_ID+k, wr_data_out = zero-extended data[k*WORD_WIDTH +: WORD_WIDTH].
  - On wr_ack_in: if k==SAMPLES-1 go to WRITE_VALID, else k<=k+1.
- WRITE_VALID:
  - wr_en_out=1, wr_id_out=VALID_ID, wr_data_out=1.
  - On wr_ack_in: pulse done_out in the next cycle and go to IDLE.
- Write handshake:
  - Requests are registered outputs.
  - id/data stay stable while wr_en_out=1 until wr_ack_in is seen.
  - An ack in the first cycle of a request completes that request.
  - wr_ack_in is ignored when wr_en_out=0.
- Latency with wr_ack_in tied high:
  - accept at cycle t;
  - slice writes at t+1..t+SAMPLES;
  - valid write at t+SAMPLES+1;
  - done_out and data_ready_out=1 at t+SAMPLES+2.
- data_ready_out=0 in WRITE and WRITE_VALID; back-to-back values are never overlapped.
- Drop counter:
  - increments every cycle with data_valid_in && !data_ready_out;
  - saturates at 2^DROP_CNT_WIDTH-1;
  - cleared only by rst.
- If valid_pending_in rises while in WRITE or WRITE_VALID, the in-progress sequence still completes; the input only gates acceptance in IDLE.
- Reset mid-sequence:
  - immediate return to IDLE, wr_en_out=0;
  - slices already written stay in the mem map, but VALID_ID is never written for that value, so the PS never sees a torn value as valid.
- Elaboration checks (fatal):
  - DATA_WIDTH % WORD_WIDTH == 0;
  - WORD_WIDTH <= BUS_WIDTH;
  - VALID_ID < MEM_SIZE.

Decomposition:
- Shared package (mem_layout_pkg):
  - writer state enum;
  - RTL_BIGREG base/valid ID constants already defined there;
  - a SAMPLES helper macro alongside BUFF_SAMPLES.
- No sub-module needed; the slice mux and FSM live in one module. A later PS-side bigreg assembler would reuse the same package constants.

Test Plan:
- Defaults, ack tied high, pending=0; drive 0xDEADBEEF at t:
  - writes (27,0x0000BEEF) at t+1, (28,0x0000DEAD) at t+2, (29,1) at t+3;
  - done_out and ready at t+4.
- Ack stall: hold wr_ack_in=0 for 5 cycles during slice 1:
  - wr_id_out=28 and wr_data_out=0xDEAD stable for all 5 cycles;
  - no skipped or duplicated IDs;
  - done 5 cycles later than the unstalled case.
- valid_pending_in=1 with data_valid_in held high for 10 cycles:
  - ready=0, no writes, drop_cnt=10;
  - pending drops, value accepted next cycle.
- DROP_CNT_WIDTH=4, 20 blocked cycles -> drop_cnt_out saturates at 15.
- Assert rst while WRITE k=1 (after the 27 ack):
  - wr_en_out=0 immediately (asynchronous);
  - ID 29 is never written;
  - after release, a fresh 0x12345678 produces (27,0x5678),(28,0x1234),(29,1).
- DATA_WIDTH=256, BASE_ID=33:
  - 16 slice writes at IDs 33..48, then (49,1);
  - latency 18 cycles with ack high.
